spi_slave_if: RTL and testbench

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

---
 rtl/spi_slave_if.sv | 113 +++++++++++
 tb/tb_spi_slave_if.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave with synchronized SPI inputs, a received-word output and a one-deep tx holding buffer.
module spi_slave_if #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d;
  logic cs_prev_q, cs_prev_d, sck_prev_q, sck_prev_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic word_done_q, word_done_d, hold_full_q, hold_full_d;
  logic rx_valid_q, rx_valid_d, underrun_q, underrun_d;
  logic cs_s, sck_s, mosi_s, cs_rise, cs_fall, rise, fall, last, reload, tx_fire;
  logic [DATA_W-1:0] rx_word, new_word;

  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = cs_rise ? IDLE :
              (state_q == IDLE && cs_fall) ? LOAD :
              (state_q == LOAD) ? SHIFT : state_q;
  end

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_s;
    sck_prev_d  = sck_s;
    cs_rise     = cs_s & ~cs_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
    rise        = (state_q == SHIFT) & sck_s & ~sck_prev_q;
    fall        = (state_q == SHIFT) & ~sck_s & sck_prev_q;
    last        = rise & (cnt_q == LAST);
    // a cs rising edge wins over any reload so a closing frame never consumes the buffer
    reload      = ~cs_rise & ((state_q == LOAD) | (fall & word_done_q));
    tx_fire     = tx_valid & ~hold_full_q;
    new_word    = tx_fire ? tx_data : hold_full_q ? hold_q : '0;
    rx_word     = {rx_sr_q[DATA_W-2:0], mosi_s};
    tx_sr_d     = cs_rise ? '0 : reload ? new_word : (fall & ~word_done_q) ? tx_sr_q << 1 : tx_sr_q;
    rx_sr_d     = cs_rise ? '0 : rise ? rx_word : rx_sr_q;
    cnt_d       = (cs_rise | state_q == LOAD | last) ? '0 : rise ? cnt_q + 1'b1 : cnt_q;
    word_done_d = ~cs_rise & (last | (word_done_q & ~reload));
    hold_full_d = ~reload & (tx_fire | hold_full_q);
    hold_d      = (~reload & tx_fire) ? tx_data : hold_q;
    rx_data_d   = last ? rx_word : rx_data_q;
    rx_valid_d  = last;
    underrun_d  = reload & ~tx_fire & ~hold_full_q;
    spi_miso    = tx_sr_q[DATA_W-1] & ~spi_cs;
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
    tx_ready    = ~hold_full_q;
    tx_underrun = underrun_q;
    busy        = state_q != IDLE;
  end

  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sck_prev_q  <= sck_prev_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: SPI master model plus tx supplier; received words are checked by a scoreboard monitor.
module tb_spi_slave_if;
  localparam int H = 8;
  logic CLK = 0, rst_n = 0, spi_cs = 1, spi_sck = 0, spi_mosi = 0;
  logic spi_miso, rx_valid, tx_valid, tx_ready, tx_underrun, busy;
  logic [31:0] rx_data, tx_data;
  logic [31:0] rx_q[$], tx_q[$];
  logic [31:0] mw[4], tw[4], last_rx = '0, exp_rx, snoop_word = '0;
  bit sup[4];
  bit snoop_pending = 0;
  int checks = 0, errors = 0, und_cnt = 0;

  spi_slave_if #(.DATA_W(32), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, 32'(spi_miso), 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 1);
    chk({tag, "_underrun"}, 32'(tx_underrun), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // scoreboard monitor: every rx_valid pulse must match the oldest expected word
  always @(negedge CLK) if (rst_n) begin
    if (tx_underrun) und_cnt++;
    if (rx_valid) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected got %h exp none", rx_data);
      end else begin
        exp_rx = rx_q.pop_front();
        chk("rx_word", rx_data, exp_rx);
      end
    end
  end

  // tx supplier: handshakes queued words, or drives one word in the first busy cycle
  initial begin
    bit ok, hs;
    tx_valid = 0;
    tx_data = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (snoop_pending && busy) begin
        tx_data = snoop_word;
        tx_valid = 1;
        snoop_pending = 0;
        tick(1);
        tx_valid = 0;
      end else if (tx_q.size() > 0) begin
        ok = 0;
        tx_data = tx_q[0];
        tx_valid = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
          @(negedge CLK);
          hs = tx_ready;
          @(posedge CLK);
          ok = hs;
        end
        #1;
        tx_valid = 0;
        void'(tx_q.pop_front());
        chk("tx_handshake", 32'(ok), 1);
      end
    end
  end

  task automatic run_frame(input int nw, input int stop_at, input bit rst_abort, input bit snoop);
    logic [31:0] cap;
    int total, und0, exp_und;
    bit done;
    total = 0;
    und0 = und_cnt;
    exp_und = 0;
    for (int w = 0; w < nw; w++) if (!(sup[w] || (w == 0 && snoop))) exp_und++;
    if (snoop) begin
      snoop_word = tw[0];
      snoop_pending = 1;
    end else if (sup[0]) begin
      tx_q.push_back(tw[0]);
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        tick(1);
        done = !tx_ready;
      end
      chk("preload_taken", 32'(done), 1);
    end
    spi_cs = 0;
    tick(H);
    for (int w = 0; w < nw; w++) begin
      cap = '0;
      for (int b = 31; b >= 0; b--) begin
        spi_mosi = mw[w][b];
        tick(H);
        if (b == 31 && w + 1 < nw && sup[w + 1]) tx_q.push_back(tw[w + 1]);
        if (snoop && w == 0 && b == 31) chk("snoop_tx_ready", 32'(tx_ready), 1);
        if (b == 0 && stop_at < 0) begin
          rx_q.push_back(mw[w]);
          last_rx = mw[w];
        end
        cap[b] = spi_miso;
        spi_sck = 1;
        tick(H);
        total++;
        if (total == stop_at) begin
          if (rst_abort) begin
            rst_n = 0;
            #1;
            chk_reset("midrst");
            spi_sck = 0;
            spi_cs = 1;
            tick(4);
            rst_n = 1;
            last_rx = '0;
          end else begin
            spi_sck = 0;
            spi_cs = 1;
          end
          tick(2 * H);
          chk("abort_rx_hold", rx_data, last_rx);
          chk("abort_miso", 32'(spi_miso), 0);
          chk("abort_busy", 32'(busy), 0);
          chk("abort_underruns", 32'(und_cnt - und0), 32'(exp_und));
          return;
        end
        if (w == nw - 1 && b == 0) spi_cs = 1;
        spi_sck = 0;
      end
      chk("miso_word", cap, (sup[w] || (w == 0 && snoop)) ? tw[w] : 32'h0);
    end
    tick(2 * H);
    chk("frame_underruns", 32'(und_cnt - und0), 32'(exp_und));
    chk("frame_busy", 32'(busy), 0);
    chk("frame_tx_ready", 32'(tx_ready), 1);
    chk("frame_miso", 32'(spi_miso), 0);
  endtask

  initial begin
    int nw;
    #1;
    chk_reset("reset");
    tick(3);
    rst_n = 1;
    tick(4);
    mw[0] = 32'h1234_5678; tw[0] = 32'hA5A5_0F0F; sup[0] = 1;
    run_frame(1, -1, 0, 0);
    mw[0] = 32'hDEAD_BEEF; tw[0] = 32'h1111_1111; sup[0] = 1;
    mw[1] = 32'h0000_0001; tw[1] = 32'h2222_2222; sup[1] = 1;
    run_frame(2, -1, 0, 0);
    mw[0] = 32'hFFFF_FFFF; sup[0] = 0;
    run_frame(1, -1, 0, 0);
    mw[0] = $urandom; tw[0] = $urandom; sup[0] = 1;
    run_frame(1, 17, 0, 0);
    mw[0] = 32'h8000_0001; tw[0] = $urandom; sup[0] = 1;
    run_frame(1, -1, 0, 0);
    mw[0] = $urandom; tw[0] = 32'h0BAD_F00D; sup[0] = 0;
    run_frame(1, -1, 0, 1);
    mw[0] = $urandom; tw[0] = $urandom; sup[0] = 1;
    run_frame(1, 10, 1, 0);
    mw[0] = 32'h0000_00FF; tw[0] = $urandom; sup[0] = 1;
    run_frame(1, -1, 0, 0);
    for (int f = 0; f < 6; f++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < 4; w++) begin
        mw[w] = $urandom;
        tw[w] = $urandom;
        sup[w] = $urandom_range(0, 3) != 0;
      end
      run_frame(nw, -1, 0, 0);
    end
    tick(4);
    chk("rx_queue_drained", 32'(rx_q.size()), 0);
    chk("tx_queue_drained", 32'(tx_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
